// File: rtl/uart_baud_ctrl.sv
// ---------------------------------------------------------------------------
// uart_baud_ctrl
//
// Sequencer for one UART channel's share of baudrate_gen. Turns the
// generator on and off through tx_active / rx_active and counts its baud
// ticks into frame bit positions. The TX half publishes the current bit
// index and a done pulse to the shift logic. The RX half validates the
// start bit, samples each bit in its middle, assembles the data word and
// checks the first stop bit. The two halves share nothing but the clock
// and reset.
//
// Optional feature: define UART_BAUD_CTRL_BREAK_DET_EN to enable break
// detection on rx_break. When the macro is undefined, rx_break is tied
// to 0.
//
// Parameters
//   NO_OF_SAMPLE  baud_en_rx ticks per bit (even, >= 4; matches baudrate_gen)
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1..2)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   tx_req        request one TX frame (level, sampled in TX idle)
//   tx_busy       TX frame in progress
//   tx_bit_idx    0 = start, 1..DATA_BITS = data, then stop bits
//   tx_done       one-cycle pulse at TX frame end
//   tx_active     enable for baudrate_gen TX side
//   baud_en_tx    one tick per TX bit period
//   rx_line       serial input, already synchronised to clk
//   rx_active     enable for baudrate_gen RX side
//   baud_en_rx    NO_OF_SAMPLE ticks per RX bit period
//   rx_data       last assembled word, LSB first
//   rx_done       one-cycle pulse per completed frame (valid or not)
//   rx_frame_err  qualifies rx_done: stop bit sampled 0
//   rx_break      one-cycle break pulse (optional feature)
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | waiting for tx_req
//   TX_SEND  | frame in progress, tx_bit_idx advances per baud_en_tx
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a 1->0 edge on rx_line
//   RX_START | counting to the middle of the start bit
//   RX_DATA  | sampling data bits every NO_OF_SAMPLE ticks
//   RX_STOP  | sampling the first stop bit
// ---------------------------------------------------------------------------
module uart_baud_ctrl #(
  parameter int NO_OF_SAMPLE = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_req,
  output logic                 tx_busy,
  output logic [3:0]           tx_bit_idx,
  output logic                 tx_done,
  output logic                 tx_active,
  input  logic                 baud_en_tx,
  input  logic                 rx_line,
  output logic                 rx_active,
  input  logic                 baud_en_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_frame_err,
  output logic                 rx_break
);

  localparam int CW = $clog2(NO_OF_SAMPLE) + 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_HALF = CW'(NO_OF_SAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NO_OF_SAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [3:0]    TX_LAST  = 4'(DATA_BITS + STOP_BITS);

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  tx_state_t tx_state;
  rx_state_t rx_state;

  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_prev;

`ifdef UART_BAUD_CTRL_BREAK_DET_EN
  logic rx_break_r;
  logic brk_hold;   // set after a break; cleared once rx_line is seen high
  assign rx_break = rx_break_r;
`else
  assign rx_break = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // TX sequencing
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      tx_busy    <= 1'b0;
      tx_active  <= 1'b0;
      tx_bit_idx <= '0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_req) begin
            tx_state   <= TX_SEND;
            tx_busy    <= 1'b1;
            tx_active  <= 1'b1;
            tx_bit_idx <= '0;
          end
        end
        TX_SEND: begin
          if (baud_en_tx) begin
            // The tick that ends the last stop bit closes the frame.
            if (tx_bit_idx == TX_LAST) begin
              tx_state   <= TX_IDLE;
              tx_busy    <= 1'b0;
              tx_active  <= 1'b0;
              tx_bit_idx <= '0;
              tx_done    <= 1'b1;
            end else begin
              tx_bit_idx <= tx_bit_idx + 4'd1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // RX sequencing
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state     <= RX_IDLE;
      rx_active    <= 1'b0;
      rx_cnt       <= '0;
      rx_bit_cnt   <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_prev      <= 1'b1;
`ifdef UART_BAUD_CTRL_BREAK_DET_EN
      rx_break_r   <= 1'b0;
      brk_hold     <= 1'b0;
`endif
    end else begin
      rx_prev      <= rx_line;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_BAUD_CTRL_BREAK_DET_EN
      rx_break_r   <= 1'b0;
`endif
      case (rx_state)
        RX_IDLE: begin
`ifdef UART_BAUD_CTRL_BREAK_DET_EN
          if (brk_hold) begin
            if (rx_line) begin
              brk_hold <= 1'b0;
            end
          end else if (rx_prev && !rx_line) begin
            rx_state  <= RX_START;
            rx_active <= 1'b1;
            rx_cnt    <= '0;
          end
`else
          if (rx_prev && !rx_line) begin
            rx_state  <= RX_START;
            rx_active <= 1'b1;
            rx_cnt    <= '0;
          end
`endif
        end
        RX_START: begin
          if (baud_en_rx) begin
            if (rx_cnt == CNT_HALF) begin
              rx_cnt <= '0;
              if (!rx_line) begin
                rx_state   <= RX_DATA;
                rx_bit_cnt <= '0;
              end else begin
                // Line back high at mid start bit: glitch, not a frame.
                rx_state  <= RX_IDLE;
                rx_active <= 1'b0;
              end
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (baud_en_rx) begin
            if (rx_cnt == CNT_FULL) begin
              rx_cnt   <= '0;
              // LSB arrives first, so it ends up at bit 0 after DATA_BITS shifts.
              rx_shift <= {rx_line, rx_shift[DATA_BITS-1:1]};
              if (rx_bit_cnt == LAST_BIT) begin
                rx_state <= RX_STOP;
              end else begin
                rx_bit_cnt <= rx_bit_cnt + 1'b1;
              end
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (baud_en_rx) begin
            if (rx_cnt == CNT_FULL) begin
              rx_cnt       <= '0;
              rx_state     <= RX_IDLE;
              rx_active    <= 1'b0;
              rx_data      <= rx_shift;
              rx_done      <= 1'b1;
              rx_frame_err <= ~rx_line;
`ifdef UART_BAUD_CTRL_BREAK_DET_EN
              if (!rx_line && (rx_shift == '0)) begin
                rx_break_r <= 1'b1;
                brk_hold   <= 1'b1;
              end
`endif
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        default: begin
          rx_state  <= RX_IDLE;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for uart_baud_ctrl with NO_OF_SAMPLE=16, DATA_BITS=8,
// STOP_BITS=1. A small stand-in for baudrate_gen emits baud ticks once
// every 4 cycles while the matching active output is high. One RX bit
// therefore lasts 64 cycles.
// ---------------------------------------------------------------------------
module tb_uart_baud_ctrl;

  localparam int BIT_CYC = 64;

`ifdef UART_BAUD_CTRL_BREAK_DET_EN
  localparam logic BRK_EXP = 1'b1;
`else
  localparam logic BRK_EXP = 1'b0;
`endif

  logic       clk, rst, tx_req, tx_busy, tx_done, tx_active, baud_en_tx;
  logic       rx_line, rx_active, baud_en_rx, rx_done, rx_frame_err, rx_break;
  logic [3:0] tx_bit_idx;
  logic [7:0] rx_data;

  int tests, fails;
  int tx_ticks, tx_done_cnt, rx_ticks, rx_done_cnt, rx_err_cnt, rx_brk_cnt;
  logic [3:0] idx_log [16];
  logic [7:0] last_data;
  logic       last_err, last_brk;
  logic [1:0] phase;

  uart_baud_ctrl #(.NO_OF_SAMPLE(16), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst),
    .tx_req(tx_req), .tx_busy(tx_busy), .tx_bit_idx(tx_bit_idx),
    .tx_done(tx_done), .tx_active(tx_active), .baud_en_tx(baud_en_tx),
    .rx_line(rx_line), .rx_active(rx_active), .baud_en_rx(baud_en_rx),
    .rx_data(rx_data), .rx_done(rx_done), .rx_frame_err(rx_frame_err),
    .rx_break(rx_break)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // baudrate_gen stand-in: 1-in-4-cycle ticks while enabled
  initial begin
    phase = 2'd0; baud_en_tx = 1'b0; baud_en_rx = 1'b0;
    forever begin
      @(negedge clk);
      phase = phase + 2'd1;
      baud_en_tx = tx_active && (phase == 2'd0);
      baud_en_rx = rx_active && (phase == 2'd2);
    end
  end

  // event recorder
  initial begin
    tx_ticks = 0; tx_done_cnt = 0; rx_ticks = 0; rx_done_cnt = 0;
    rx_err_cnt = 0; rx_brk_cnt = 0; last_data = '0; last_err = 1'b0; last_brk = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (baud_en_tx) begin
        if (tx_ticks < 16) idx_log[tx_ticks] = tx_bit_idx;
        tx_ticks++;
      end
      if (baud_en_rx) rx_ticks++;
      if (tx_done) tx_done_cnt++;
      if (rx_done) begin
        rx_done_cnt++;
        last_data = rx_data;
        last_err  = rx_frame_err;
        last_brk  = rx_break;
      end
      if (rx_frame_err) rx_err_cnt++;
      if (rx_break) rx_brk_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send_rx(input logic [7:0] d, input logic stop_v);
    @(negedge clk);
    rx_line = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx_line = stop_v;
    repeat (BIT_CYC) @(negedge clk);
    rx_line = 1'b1;
    repeat (70) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [18:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    outs = {tx_busy, tx_bit_idx, tx_done, tx_active, rx_active, rx_data,
            rx_done, rx_frame_err, rx_break};
    tests++;
    if (outs !== 19'd0) begin
      fails++; $display("FAIL reset_outputs: got %0h expected 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_tx_single();
    tx_ticks = 0; tx_done_cnt = 0;
    @(negedge clk);
    tx_req = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
    #2;
    tests++;
    if (tx_busy !== 1'b1) begin fails++; $display("FAIL tx_busy_rise: got %0b expected 1", tx_busy); end
    tests++;
    if (tx_bit_idx !== 4'd0) begin fails++; $display("FAIL tx_idx_start: got %0d expected 0", tx_bit_idx); end
    for (int i = 0; i < 200 && tx_done_cnt < 1; i++) begin @(negedge clk); #2; end
    tests++;
    if ({tx_done, tx_busy, tx_active} !== 3'b100) begin
      fails++; $display("FAIL tx_end_state: got done/busy/active=%b expected 100", {tx_done, tx_busy, tx_active});
    end
    tests++;
    if (tx_ticks !== 10) begin fails++; $display("FAIL tx_tick_count: got %0d expected 10", tx_ticks); end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (idx_log[i] !== 4'(i)) begin
        fails++; $display("FAIL tx_idx_seq[%0d]: got %0d expected %0d", i, idx_log[i], i);
      end
    end
    repeat (10) @(negedge clk);
    #2;
    tests++;
    if (tx_done_cnt !== 1) begin fails++; $display("FAIL tx_done_count: got %0d expected 1", tx_done_cnt); end
  endtask

  task automatic test_rx_valid();
    rx_ticks = 0; rx_done_cnt = 0; rx_err_cnt = 0;
    send_rx(8'hA5, 1'b1);
    tests++;
    if (rx_done_cnt !== 1) begin fails++; $display("FAIL rx_valid_done: got %0d expected 1", rx_done_cnt); end
    tests++;
    if (last_data !== 8'hA5) begin fails++; $display("FAIL rx_valid_data: got %0h expected a5", last_data); end
    tests++;
    if (last_err !== 1'b0 || rx_err_cnt !== 0) begin
      fails++; $display("FAIL rx_valid_err: got %0b/%0d expected 0/0", last_err, rx_err_cnt);
    end
    tests++;
    if (rx_ticks !== 152) begin fails++; $display("FAIL rx_active_ticks: got %0d expected 152", rx_ticks); end
    tests++;
    if (rx_active !== 1'b0) begin fails++; $display("FAIL rx_valid_idle: got %0b expected 0", rx_active); end
  endtask

  task automatic test_rx_glitch();
    rx_ticks = 0; rx_done_cnt = 0;
    @(negedge clk);
    rx_line = 1'b0;
    repeat (12) @(negedge clk);
    rx_line = 1'b1;
    repeat (100) @(negedge clk);
    #2;
    tests++;
    if (rx_done_cnt !== 0) begin fails++; $display("FAIL glitch_done: got %0d expected 0", rx_done_cnt); end
    tests++;
    if (rx_ticks !== 8) begin fails++; $display("FAIL glitch_ticks: got %0d expected 8", rx_ticks); end
    tests++;
    if (rx_active !== 1'b0) begin fails++; $display("FAIL glitch_active: got %0b expected 0", rx_active); end
    tests++;
    if (rx_data !== 8'hA5) begin fails++; $display("FAIL glitch_data_hold: got %0h expected a5", rx_data); end
  endtask

  task automatic test_rx_frame_err();
    rx_done_cnt = 0; rx_err_cnt = 0;
    send_rx(8'h3C, 1'b0);
    tests++;
    if (rx_done_cnt !== 1) begin fails++; $display("FAIL ferr_done: got %0d expected 1", rx_done_cnt); end
    tests++;
    if (last_err !== 1'b1 || rx_err_cnt !== 1) begin
      fails++; $display("FAIL ferr_flag: got %0b/%0d expected 1/1", last_err, rx_err_cnt);
    end
    tests++;
    if (last_data !== 8'h3C) begin fails++; $display("FAIL ferr_data: got %0h expected 3c", last_data); end
  endtask

  task automatic test_back_to_back();
    int gap;
    gap = 0;
    tx_done_cnt = 0; rx_done_cnt = 0; rx_err_cnt = 0;
    fork
      send_rx(8'h5A, 1'b1);
      begin
        tx_req = 1'b1;
        for (int i = 0; i < 20 && tx_busy !== 1'b1; i++) begin @(negedge clk); #2; end
        for (int i = 0; i < 100 && tx_busy === 1'b1; i++) begin @(negedge clk); #2; end
        for (int i = 0; i < 20 && tx_busy !== 1'b1; i++) begin gap++; @(negedge clk); #2; end
        for (int i = 0; i < 100 && tx_done_cnt < 2; i++) begin @(negedge clk); #2; end
        tx_req = 1'b0;
      end
    join
    tests++;
    if (gap !== 1) begin fails++; $display("FAIL b2b_gap: got %0d expected 1", gap); end
    tests++;
    if (tx_done_cnt !== 2) begin fails++; $display("FAIL b2b_tx_done: got %0d expected 2", tx_done_cnt); end
    tests++;
    if (tx_busy !== 1'b0) begin fails++; $display("FAIL b2b_tx_stop: got %0b expected 0", tx_busy); end
    tests++;
    if (rx_done_cnt !== 1 || last_data !== 8'h5A || last_err !== 1'b0) begin
      fails++; $display("FAIL overlap_rx: got cnt=%0d data=%0h err=%0b expected 1/5a/0",
                        rx_done_cnt, last_data, last_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [18:0] outs;
    @(negedge clk);
    tx_req = 1'b1;
    rx_line = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    rx_line = 1'b1;
    repeat (4 * BIT_CYC + 20) @(negedge clk);
    #2;
    tests++;
    if (rx_active !== 1'b1) begin fails++; $display("FAIL mid_rx_active: got %0b expected 1", rx_active); end
    rst = 1'b1;
    tx_req = 1'b0;
    rx_done_cnt = 0; tx_done_cnt = 0;
    @(negedge clk);
    #2;
    outs = {tx_busy, tx_bit_idx, tx_done, tx_active, rx_active, rx_data,
            rx_done, rx_frame_err, rx_break};
    tests++;
    if (outs !== 19'd0) begin fails++; $display("FAIL mid_reset_outputs: got %0h expected 0", outs); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    #2;
    tests++;
    if (rx_done_cnt !== 0 || tx_done_cnt !== 0) begin
      fails++; $display("FAIL mid_no_done: got rx=%0d tx=%0d expected 0/0", rx_done_cnt, tx_done_cnt);
    end
  endtask

  task automatic test_break();
    rx_done_cnt = 0; rx_err_cnt = 0; rx_brk_cnt = 0;
    @(negedge clk);
    rx_line = 1'b0;
    repeat (11 * BIT_CYC) @(negedge clk);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    tests++;
    if (rx_done_cnt !== 1 || last_err !== 1'b1 || last_data !== 8'h00) begin
      fails++; $display("FAIL break_frame: got cnt=%0d err=%0b data=%0h expected 1/1/00",
                        rx_done_cnt, last_err, last_data);
    end
    tests++;
    if (last_brk !== BRK_EXP || rx_brk_cnt !== int'(BRK_EXP)) begin
      fails++; $display("FAIL break_flag: got %0b/%0d expected %0b", last_brk, rx_brk_cnt, BRK_EXP);
    end
    send_rx(8'h81, 1'b1);
    tests++;
    if (rx_done_cnt !== 2 || last_data !== 8'h81 || last_brk !== 1'b0 || last_err !== 1'b0) begin
      fails++; $display("FAIL break_recover: got cnt=%0d data=%0h brk=%0b err=%0b expected 2/81/0/0",
                        rx_done_cnt, last_data, last_brk, last_err);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; tx_req = 1'b0; rx_line = 1'b1;
    test_reset();
    test_tx_single();
    test_rx_valid();
    test_rx_glitch();
    test_rx_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
